fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one `fifo` instance's write port between `NUM_REQ` producers (e.g. systolic-array row drains). Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for a burst of at most `BURST_LEN` words and drives the FIFO's `fifo_we`/`fifo_in`. It honours `fifo_full` as backpressure.

---
 rtl/fifo_wr_arbiter_if.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 108 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side signal bundle for fifo_wr_arbiter.
// The master modport is the arbiter's view; slave is the producers/FIFO/environment side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_we;
  logic signed [WIDTH-1:0]  fifo_in;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_we, fifo_in, grant, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_we, fifo_in, grant, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers,
// granting bursts of up to BURST_LEN words with a one-cycle idle gap between grants.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned BURST_LEN = 8
) (
  input logic               arb_clk,
  input logic               arb_rst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]    burst_cnt_q, burst_cnt_d;

  logic [PtrW-1:0] owner;
  logic [PtrW-1:0] pick;
  logic [PtrW-1:0] scan;
  logic            pick_vld;
  logic            last_word;

  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner = PtrW'(i);
    end
  end

  // Scan rr_ptr, rr_ptr+1, ... with wrap; the first valid requester wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = PtrW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_vld && bus.req_valid[scan]) begin
        pick     = scan;
        pick_vld = 1'b1;
      end
    end
  end

  // Outputs decode from registered state so reset clears them immediately.
  always_comb begin
    bus.req_ready = '0;
    bus.fifo_we   = 1'b0;
    bus.fifo_in   = '0;
    if (state_q == StGrant) begin
      bus.req_ready[owner] = !bus.fifo_full;
      bus.fifo_we          = bus.req_valid[owner] && !bus.fifo_full;
      bus.fifo_in          = bus.req_data[owner*WIDTH +: WIDTH];
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = (state_q == StGrant);

  assign last_word = (burst_cnt_q == CntW'(BURST_LEN - 1));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d       = StGrant;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          burst_cnt_d   = '0;
        end
      end
      StGrant: begin
        // A dropped valid forfeits the rest of the burst; a full FIFO simply stalls.
        if (!bus.req_valid[owner] || (!bus.fifo_full && last_word)) begin
          state_d     = StIdle;
          grant_d     = '0;
          burst_cnt_d = '0;
          rr_ptr_d    = (owner == PtrW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end else if (!bus.fifo_full) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: queued producers, expected FIFO words and grant log.
module tb_fifo_wr_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 16;

  logic arb_clk   = 1'b0;
  logic arb_rst_n = 1'b0;
  always #5 arb_clk = ~arb_clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) ifc ();
  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) ifc1 ();

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .BURST_LEN(8)) dut (
    .arb_clk  (arb_clk),
    .arb_rst_n(arb_rst_n),
    .bus      (ifc)
  );

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .BURST_LEN(1)) dut1 (
    .arb_clk  (arb_clk),
    .arb_rst_n(arb_rst_n),
    .bus      (ifc1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Producer word stores (hold valid while non-empty).
  logic [WIDTH-1:0] pmem [NUM_REQ][32];
  int phead [NUM_REQ];
  int ptail [NUM_REQ];

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];
  int we_cyc[$];
  int burst_owner[$];
  int burst_words[$];
  int burst_cycles[$];
  int gap_q[$];
  int cur_words, cur_cycles, idle_run, onehot_bad;
  bit prev_busy;

  function automatic int oh_idx(logic [NUM_REQ-1:0] v);
    oh_idx = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) oh_idx = i;
  endfunction

  function automatic bit drained();
    drained = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (phead[i] != ptail[i]) drained = 1'b0;
  endfunction

  task automatic push_word(input int p, input logic [WIDTH-1:0] w, input bit expect_it);
    pmem[p][ptail[p]] = w;
    ptail[p]++;
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      ifc.req_valid[i] = (phead[i] != ptail[i]);
      ifc.req_data[i*WIDTH +: WIDTH] = (phead[i] != ptail[i]) ? pmem[i][phead[i]] : '0;
    end
  endtask

  // Called at a negedge: log what the DUT shows, then step one clock and update producers.
  task automatic advance();
    logic [NUM_REQ-1:0] acc;
    acc = ifc.req_valid & ifc.req_ready;
    if (ifc.fifo_we) begin
      got_q.push_back(ifc.fifo_in);
      we_cyc.push_back(cyc);
    end
    if (ifc.busy) begin
      if (!$onehot(ifc.grant)) onehot_bad++;
      if (!prev_busy) begin
        burst_owner.push_back(oh_idx(ifc.grant));
        gap_q.push_back(idle_run);
        cur_words  = 0;
        cur_cycles = 0;
      end
      if (ifc.fifo_we) cur_words++;
      cur_cycles++;
      idle_run = 0;
    end else begin
      if (prev_busy) begin
        burst_words.push_back(cur_words);
        burst_cycles.push_back(cur_cycles);
      end
      idle_run++;
    end
    prev_busy = ifc.busy;
    cyc++;
    @(posedge arb_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (acc[i]) phead[i]++;
    apply_inputs();
  endtask

  task automatic run_until_drained(input int budget, output bit ok);
    int c;
    ok = 1'b0;
    for (c = 0; c < budget; c++) begin
      @(negedge arb_clk);
      advance();
      if (drained() && !ifc.busy && !prev_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    arb_rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end
    ifc.fifo_full  = 1'b0;
    ifc1.fifo_full = 1'b0;
    ifc1.req_valid = '0;
    ifc1.req_data  = '0;
    apply_inputs();
    exp_q.delete(); got_q.delete(); we_cyc.delete();
    burst_owner.delete(); burst_words.delete(); burst_cycles.delete(); gap_q.delete();
    prev_busy = 1'b0; idle_run = 0; cur_words = 0; cur_cycles = 0; onehot_bad = 0;
    repeat (2) @(posedge arb_clk);
    @(negedge arb_clk);
    arb_rst_n = 1'b1;
    @(posedge arb_clk);
    #1;
  endtask

  task automatic test_reset();
    arb_rst_n = 1'b0;
    phead[1] = 0; ptail[1] = 0;
    push_word(1, 16'h5A5A, 1'b0);
    ifc.fifo_full = 1'b0;
    apply_inputs();
    @(posedge arb_clk);
    #1;
    n_vec++; if (ifc.grant !== '0) begin n_err++; $display("FAIL rst_grant: got %b want 0", ifc.grant); end
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", ifc.busy); end
    n_vec++; if (ifc.fifo_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", ifc.fifo_we); end
    n_vec++; if (ifc.req_ready !== '0) begin n_err++; $display("FAIL rst_ready: got %b want 0", ifc.req_ready); end
    n_vec++; if (ifc.fifo_in !== '0) begin n_err++; $display("FAIL rst_fifo_in: got %h want 0", ifc.fifo_in); end
    do_reset();
    push_word(1, 16'h5A5A, 1'b0);
    apply_inputs();
    @(negedge arb_clk);
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL latency_idle: busy %b want 0", ifc.busy); end
    advance();
    @(negedge arb_clk);
    n_vec++; if (ifc.grant !== 4'b0010) begin n_err++; $display("FAIL latency_grant: got %b want 0010", ifc.grant); end
    n_vec++; if (ifc.fifo_we !== 1'b1 || ifc.fifo_in !== 16'h5A5A) begin
      n_err++; $display("FAIL latency_word: we %b data %h want 1 5a5a", ifc.fifo_we, ifc.fifo_in);
    end
  endtask

  task automatic test_single_stream();
    bit ok;
    int eo[$], ew[$], ec[$];
    do_reset();
    for (int k = 0; k < 20; k++) push_word(1, WIDTH'(k), 1'b1);
    apply_inputs();
    run_until_drained(100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_timeout: got 0 want 1"); end
    n_vec++; if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL single_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    eo = '{1, 1, 1}; ew = '{8, 8, 4}; ec = '{8, 8, 5};
    n_vec++; if (burst_owner != eo || burst_words != ew || burst_cycles != ec) begin
      n_err++; $display("FAIL single_bursts: owners %p words %p cycles %p want %p %p %p",
                        burst_owner, burst_words, burst_cycles, eo, ew, ec);
    end
    for (int i = 1; i < gap_q.size(); i++) begin
      n_vec++; if (gap_q[i] != 1) begin n_err++; $display("FAIL single_gap[%0d]: got %0d want 1", i, gap_q[i]); end
    end
    n_vec++; if (we_cyc.size() == 20 && (we_cyc[19] - we_cyc[0] + 1) != 22) begin
      n_err++; $display("FAIL single_span: got %0d want 22", we_cyc[19] - we_cyc[0] + 1);
    end
  endtask

  task automatic test_all_four();
    bit ok;
    int eo[$];
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < ((i == 0) ? 16 : 8); k++) push_word(i, {4'(i), 12'(k)}, 1'b0);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r == 0 || i == 0) for (int k = 0; k < 8; k++) exp_q.push_back({4'(i), 12'(r*8 + k)});
      end
    end
    apply_inputs();
    run_until_drained(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL all4_timeout: got 0 want 1"); end
    n_vec++; if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL all4_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL all4_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    eo = '{0, 1, 2, 3, 0};
    n_vec++; if (burst_owner != eo) begin n_err++; $display("FAIL all4_order: got %p want %p", burst_owner, eo); end
    for (int i = 0; i < burst_words.size(); i++) begin
      n_vec++; if (burst_words[i] != 8 || burst_cycles[i] != 8) begin
        n_err++; $display("FAIL all4_burst[%0d]: got %0d words %0d cycles want 8 8", i, burst_words[i], burst_cycles[i]);
      end
    end
    n_vec++; if (onehot_bad != 0) begin n_err++; $display("FAIL all4_onehot: got %0d bad want 0", onehot_bad); end
  endtask

  task automatic test_backpressure();
    int full_left = -1;
    int stalls = 0;
    int eo[$], ew[$];
    do_reset();
    for (int k = 0; k < 8; k++) push_word(0, 16'h0B00 + WIDTH'(k), 1'b1);
    apply_inputs();
    for (int c = 0; c < 100; c++) begin
      @(negedge arb_clk);
      if (ifc.fifo_full) begin
        stalls++;
        n_vec++; if (ifc.req_ready[0] !== 1'b0 || ifc.fifo_we !== 1'b0 || ifc.busy !== 1'b1) begin
          n_err++; $display("FAIL bp_stall: ready %b we %b busy %b want 0 0 1", ifc.req_ready[0], ifc.fifo_we, ifc.busy);
        end
        n_vec++; if (dut.burst_cnt_q !== 3'd3) begin
          n_err++; $display("FAIL bp_cnt: got %0d want 3", dut.burst_cnt_q);
        end
      end
      advance();
      if (full_left > 0) begin
        full_left--;
        if (full_left == 0) ifc.fifo_full = 1'b0;
      end else if (full_left < 0 && got_q.size() == 3) begin
        ifc.fifo_full = 1'b1;
        full_left = 5;
      end
      if (burst_words.size() > 0) break;
    end
    n_vec++; if (stalls != 5) begin n_err++; $display("FAIL bp_stalls: got %0d want 5", stalls); end
    eo = '{0}; ew = '{8};
    n_vec++; if (burst_owner != eo || burst_words != ew) begin
      n_err++; $display("FAIL bp_burst: owners %p words %p want %p %p", burst_owner, burst_words, eo, ew);
    end
    n_vec++; if (got_q != exp_q) begin n_err++; $display("FAIL bp_words: got %p want %p", got_q, exp_q); end
  endtask

  task automatic test_early_release();
    bit loaded = 1'b0;
    int eo[$], ew[$];
    do_reset();
    for (int k = 0; k < 2; k++) push_word(3, 16'h3000 + WIDTH'(k), 1'b1);
    apply_inputs();
    for (int c = 0; c < 100; c++) begin
      @(negedge arb_clk);
      advance();
      if (!loaded && ifc.grant[3]) begin
        for (int k = 0; k < 8; k++) push_word(0, 16'h0E00 + WIDTH'(k), 1'b1);
        apply_inputs();
        loaded = 1'b1;
      end
      if (burst_words.size() == 2) break;
    end
    eo = '{3, 0}; ew = '{2, 8};
    n_vec++; if (burst_owner != eo || burst_words != ew) begin
      n_err++; $display("FAIL early_bursts: owners %p words %p want %p %p", burst_owner, burst_words, eo, ew);
    end
    n_vec++; if (burst_cycles.size() < 1 || burst_cycles[0] != 3) begin
      n_err++; $display("FAIL early_release_cycle: got %p want first 3", burst_cycles);
    end
    n_vec++; if (gap_q.size() < 2 || gap_q[1] != 1) begin n_err++; $display("FAIL early_gap: got %p want second 1", gap_q); end
    n_vec++; if (got_q != exp_q) begin n_err++; $display("FAIL early_words: got %p want %p", got_q, exp_q); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int eo[$], ew[$];
    do_reset();
    for (int k = 0; k < 8; k++) push_word(2, 16'h2000 + WIDTH'(k), 1'b1);
    apply_inputs();
    for (int c = 0; c < 50 && got_q.size() < 3; c++) begin
      @(negedge arb_clk);
      advance();
    end
    n_vec++; if (got_q.size() != 3 || got_q[2] !== 16'h2002) begin
      n_err++; $display("FAIL mid_pre_words: got %p want 3 words ending 2002", got_q);
    end
    #1;
    n_vec++; if (ifc.fifo_we !== 1'b1) begin n_err++; $display("FAIL mid_pre_we: got %b want 1", ifc.fifo_we); end
    arb_rst_n = 1'b0;
    #1;
    n_vec++; if (ifc.grant !== '0 || ifc.fifo_we !== 1'b0 || ifc.busy !== 1'b0 || ifc.req_ready !== '0) begin
      n_err++; $display("FAIL mid_async: grant %b we %b busy %b ready %b want 0 0 0 0",
                        ifc.grant, ifc.fifo_we, ifc.busy, ifc.req_ready);
    end
    do_reset();
    for (int k = 0; k < 4; k++) push_word(0, 16'h0D00 + WIDTH'(k), 1'b1);
    for (int k = 3; k < 8; k++) push_word(2, 16'h2000 + WIDTH'(k), 1'b1);
    apply_inputs();
    run_until_drained(100, ok);
    eo = '{0, 2}; ew = '{4, 5};
    n_vec++; if (!ok || burst_owner != eo || burst_words != ew) begin
      n_err++; $display("FAIL mid_after: ok %0d owners %p words %p want 1 %p %p", ok, burst_owner, burst_words, eo, ew);
    end
    n_vec++; if (got_q != exp_q) begin n_err++; $display("FAIL mid_words: got %p want %p", got_q, exp_q); end
  endtask

  task automatic test_burst_len_one();
    bit exp_we;
    logic [NUM_REQ-1:0] exp_gnt;
    logic [WIDTH-1:0] exp_data;
    do_reset();
    ifc1.req_valid = 4'b0110;
    ifc1.req_data  = {16'h0000, 16'h2222, 16'h1111, 16'h0000};
    for (int c = 0; c < 12; c++) begin
      @(negedge arb_clk);
      exp_we   = (c % 2) == 1;
      exp_gnt  = ((c % 4) == 1) ? 4'b0010 : 4'b0100;
      exp_data = ((c % 4) == 1) ? 16'h1111 : 16'h2222;
      n_vec++; if (ifc1.fifo_we !== exp_we || ifc1.busy !== exp_we) begin
        n_err++; $display("FAIL bl1_we[%0d]: we %b busy %b want %b", c, ifc1.fifo_we, ifc1.busy, exp_we);
      end
      if (exp_we) begin
        n_vec++; if (ifc1.grant !== exp_gnt || ifc1.fifo_in !== exp_data) begin
          n_err++; $display("FAIL bl1_grant[%0d]: grant %b data %h want %b %h", c, ifc1.grant, ifc1.fifo_in, exp_gnt, exp_data);
        end
      end
      @(posedge arb_clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifc.req_valid  = '0;
    ifc.req_data   = '0;
    ifc.fifo_full  = 1'b0;
    ifc1.req_valid = '0;
    ifc1.req_data  = '0;
    ifc1.fifo_full = 1'b0;
    test_reset();
    test_single_stream();
    test_all_four();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    test_burst_len_one();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
